// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending state encoding and default widths
package vend_pkg;

  localparam int CREDIT_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COMPARE  = 3'd1,
    S_DISPENSE = 3'd2,
    S_CHANGE   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/vend_coin_pulser.sv
// rtl/vend_coin_pulser.sv - change downcounter emitting coin pulses spaced by COIN_GAP
module vend_coin_pulser #(
  parameter int CREDIT_W = 8,
  parameter int COIN_GAP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_load_val,
  input  logic                i_active,
  output logic                o_coin,
  output logic                o_last,
  output logic                o_nonzero
);

  localparam int GW = (COIN_GAP > 2) ? $clog2(COIN_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(COIN_GAP - 1);

  logic [CREDIT_W-1:0] r_change;
  logic [GW-1:0]       r_gap;

  // Loading also zeroes the gap so the first CHANGE cycle always pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_change <= '0;
      r_gap    <= '0;
    end else if (i_load) begin
      r_change <= i_load_val;
      r_gap    <= '0;
    end else if (i_active) begin
      if (r_gap == '0) begin
        r_change <= r_change - CREDIT_W'(1);
        r_gap    <= GAP_RELOAD;
      end else begin
        r_gap    <= r_gap - GW'(1);
      end
    end
  end

  assign o_coin    = i_active && (r_gap == '0);
  assign o_last    = (r_change == CREDIT_W'(1));
  assign o_nonzero = (r_change != '0);

endmodule

// File: rtl/vend_dispense_fsm.sv
// rtl/vend_dispense_fsm.sv - credit/price compare, motor drive with timeout, change/refund sequencing
module vend_dispense_fsm
  import vend_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF,
  parameter int COIN_GAP = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic [CREDIT_W-1:0] price,
  input  logic                dispense_done,
  output logic                dispense,
  output logic                coin_out,
  output logic                busy,
  output logic                done,
  output logic                insufficient,
  output logic                fault,
  output logic [2:0]          state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_price;
  logic [TW-1:0]       r_timer;
  logic                r_insuff;
  logic                r_fault;

  logic                w_latch;
  logic                w_load;
  logic [CREDIT_W-1:0] w_load_val;
  logic                w_set_insuff;
  logic                w_set_fault;
  logic                w_coin;
  logic                w_last;
  logic                w_nonzero;

  vend_coin_pulser #(
    .CREDIT_W (CREDIT_W),
    .COIN_GAP (COIN_GAP)
  ) u_pulser (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_active   (r_state == S_CHANGE),
    .o_coin     (w_coin),
    .o_last     (w_last),
    .o_nonzero  (w_nonzero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_load       = 1'b0;
    w_load_val   = r_credit;
    w_set_insuff = 1'b0;
    w_set_fault  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_latch = 1'b1;
          w_next  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        w_load = 1'b1;
        if (r_credit >= r_price) begin
          w_load_val = r_credit - r_price;
          w_next     = S_DISPENSE;
        end else begin
          w_set_insuff = 1'b1;
          w_next       = (r_credit == '0) ? S_DONE : S_CHANGE;
        end
      end
      S_DISPENSE: begin
        // An acknowledge on the final timer cycle beats the timeout.
        if (dispense_done) begin
          w_next = w_nonzero ? S_CHANGE : S_DONE;
        end else if (r_timer == TMO_LAST) begin
          w_set_fault = 1'b1;
          w_load      = 1'b1;
          w_next      = (r_credit == '0) ? S_DONE : S_CHANGE;
        end
      end
      S_CHANGE: begin
        if (w_coin && w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= '0;
      r_price  <= '0;
      r_timer  <= '0;
      r_insuff <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_credit <= credit;
        r_price  <= price;
        r_insuff <= 1'b0;
        r_fault  <= 1'b0;
      end
      if (w_set_insuff) r_insuff <= 1'b1;
      if (w_set_fault)  r_fault  <= 1'b1;
      if (r_state == S_COMPARE)       r_timer <= '0;
      else if (r_state == S_DISPENSE) r_timer <= r_timer + TW'(1);
    end
  end

  assign dispense     = (r_state == S_DISPENSE);
  assign coin_out     = w_coin;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign insufficient = r_insuff;
  assign fault        = r_fault;
  assign state        = r_state;

endmodule
